// File: rtl/l2req_arbiter_n_pkg.sv
// rtl/l2req_arbiter_n_pkg.sv - shared L2 request packet type and arbiter helpers
package l2req_arbiter_n_pkg;

    localparam int L2_ADDR_W = 32;
    localparam int L2_TAG_W  = 6;

    typedef enum logic [1:0] {
        L2_CMD_READ     = 2'd0,
        L2_CMD_WRITE    = 2'd1,
        L2_CMD_PREFETCH = 2'd2,
        L2_CMD_FLUSH    = 2'd3
    } l2req_cmd_e;

    typedef struct packed {
        logic                 valid;
        l2req_cmd_e           cmd;
        logic [L2_TAG_W-1:0]  tag;
        logic [L2_ADDR_W-1:0] addr;
    } l2req_packet_t;

    // A single requester still needs a one-bit pointer so the arbiter ports stay legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2req_arbiter_n_if.sv
// rtl/l2req_arbiter_n_if.sv - requester-side and L2-side handshake bundle
interface l2req_arbiter_n_if #(
    parameter int NUM_REQUESTERS = 3
) ();
    import l2req_arbiter_n_pkg::*;

    l2req_packet_t [NUM_REQUESTERS-1:0] req_packet;
    logic          [NUM_REQUESTERS-1:0] req_ready;
    logic                               l2req_ready;
    l2req_packet_t                      l2req_packet;

    modport slave (
        input  req_packet,
        input  l2req_ready,
        output req_ready,
        output l2req_packet
    );

    modport master (
        output req_packet,
        output l2req_ready,
        input  req_ready,
        input  l2req_packet
    );
endinterface

// File: rtl/l2req_arbiter_n_rr_arbiter.sv
// rtl/l2req_arbiter_n_rr_arbiter.sv - one-hot winner select, fixed or rotating priority
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          mode_i,
    output logic [N-1:0]  grant_o
);
    logic [PW-1:0]  eff_ptr;
    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;
    logic [2*N-1:0] pick2;

    // Rotate so the pointer position becomes bit 0, take the lowest set bit, rotate back.
    assign eff_ptr = mode_i ? ptr_i : '0;
    assign req2    = {req_i, req_i};
    assign rot     = N'(req2 >> eff_ptr);

    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick    = '0;
                pick[k] = 1'b1;
            end
        end
    end

    assign pick2   = {{N{1'b0}}, pick} << eff_ptr;
    assign grant_o = pick2[N-1:0] | pick2[2*N-1:N];

endmodule

// File: rtl/l2req_arbiter_n.sv
// rtl/l2req_arbiter_n.sv - N-source arbiter feeding a single registered L2 request slot
module l2req_arbiter_n
    import l2req_arbiter_n_pkg::*;
#(
    parameter int NUM_REQUESTERS = 3,
    parameter int ARB_MODE       = 1
) (
    input  logic              clk,
    input  logic              reset,
    l2req_arbiter_n_if.slave  bus,
    output logic              pc_event_arb_conflict
);
    localparam int PW = ptr_width(NUM_REQUESTERS);

    logic [NUM_REQUESTERS-1:0] req_valid;
    logic [NUM_REQUESTERS-1:0] req_masked;
    logic [NUM_REQUESTERS-1:0] grant;
    logic [PW-1:0]             ptr_q, ptr_d, grant_idx;
    l2req_packet_t             out_q, out_d, sel_pkt;
    logic                      load;
    logic                      any_grant;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            req_valid[i] = bus.req_packet[i].valid;
        end
    end

    // The slot can take a new packet when empty or when L2 drains it this cycle.
    assign load       = !out_q.valid || bus.l2req_ready;
    assign req_masked = (load && !reset) ? req_valid : '0;

    rr_arbiter #(
        .N  (NUM_REQUESTERS),
        .PW (PW)
    ) u_rr_arbiter (
        .req_i   (req_masked),
        .ptr_i   (ptr_q),
        .mode_i  (ARB_MODE == 1),
        .grant_o (grant)
    );

    assign any_grant = |grant;

    always_comb begin
        sel_pkt   = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant[i]) begin
                sel_pkt   = bus.req_packet[i];
                grant_idx = PW'(i);
            end
        end
    end

    always_comb begin
        out_d = out_q;
        if (load) begin
            out_d = any_grant ? sel_pkt : '0;
        end
        ptr_d = ptr_q;
        if (any_grant) begin
            ptr_d = (grant_idx == PW'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    generate
        if (ARB_MODE == 1) begin : g_rr_ptr
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end else begin : g_fixed_ptr
            assign ptr_q = '0;
        end
    endgenerate

    assign bus.req_ready         = grant;
    assign bus.l2req_packet      = out_q;
    assign pc_event_arb_conflict = any_grant && ($countones(req_valid) > 1);

endmodule

// File: tb/tb_l2req_arbiter_n.sv
// tb/tb_l2req_arbiter_n.sv - self-checking bench for l2req_arbiter_n
module tb_l2req_arbiter_n;
    import l2req_arbiter_n_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic conf_rr, conf_fp, conf_one;

    l2req_arbiter_n_if #(.NUM_REQUESTERS(3)) if_rr  ();
    l2req_arbiter_n_if #(.NUM_REQUESTERS(3)) if_fp  ();
    l2req_arbiter_n_if #(.NUM_REQUESTERS(1)) if_one ();

    l2req_arbiter_n #(.NUM_REQUESTERS(3), .ARB_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .bus(if_rr), .pc_event_arb_conflict(conf_rr));
    l2req_arbiter_n #(.NUM_REQUESTERS(3), .ARB_MODE(0)) u_fp (
        .clk(clk), .reset(reset), .bus(if_fp), .pc_event_arb_conflict(conf_fp));
    l2req_arbiter_n #(.NUM_REQUESTERS(1), .ARB_MODE(1)) u_one (
        .clk(clk), .reset(reset), .bus(if_one), .pc_event_arb_conflict(conf_one));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int n_of[3]    = '{3, 3, 1};
    int mode_of[3] = '{1, 0, 1};

    logic          m_valid[3];
    l2req_packet_t m_pkt[3];
    int            m_ptr[3];
    int            win[3];
    logic          ld[3];
    l2req_packet_t cand[3];
    logic [7:0]    exp_ready[3];
    logic          exp_conf[3];
    logic [7:0]    obs_ready[3];
    logic          obs_conf[3];
    l2req_packet_t obs_pkt[3];

    function automatic l2req_packet_t rand_pkt();
        l2req_packet_t p;
        p.valid = 1'b1;
        p.cmd   = l2req_cmd_e'($urandom_range(0, 3));
        p.tag   = L2_TAG_W'($urandom);
        p.addr  = $urandom;
        return p;
    endfunction

    function automatic l2req_packet_t src_pkt(input int d, input int s);
        case (d)
            0:       return if_rr.req_packet[s];
            1:       return if_fp.req_packet[s];
            default: return if_one.req_packet[0];
        endcase
    endfunction

    function automatic logic rdy_of(input int d);
        case (d)
            0:       return if_rr.l2req_ready;
            1:       return if_fp.l2req_ready;
            default: return if_one.l2req_ready;
        endcase
    endfunction

    function automatic logic [7:0] get_ready(input int d);
        case (d)
            0:       return 8'(if_rr.req_ready);
            1:       return 8'(if_fp.req_ready);
            default: return 8'(if_one.req_ready);
        endcase
    endfunction

    function automatic logic get_conf(input int d);
        case (d)
            0:       return conf_rr;
            1:       return conf_fp;
            default: return conf_one;
        endcase
    endfunction

    function automatic l2req_packet_t get_pkt(input int d);
        case (d)
            0:       return if_rr.l2req_packet;
            1:       return if_fp.l2req_packet;
            default: return if_one.l2req_packet;
        endcase
    endfunction

    // First valid source found scanning upward from start, wrapping at n.
    function automatic int winner_of(input logic [7:0] v, input int n, input int start);
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    task automatic set_src(input int d, input int s, input l2req_packet_t p);
        case (d)
            0:       if_rr.req_packet[s] = p;
            1:       if_fp.req_packet[s] = p;
            default: if_one.req_packet[0] = p;
        endcase
    endtask

    task automatic set_rdy(input int d, input logic r);
        case (d)
            0:       if_rr.l2req_ready = r;
            1:       if_fp.l2req_ready = r;
            default: if_one.l2req_ready = r;
        endcase
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < n_of[d]; s++) set_src(d, s, '0);
            set_rdy(d, 1'b1);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0;
            m_pkt[d]   = '0;
            m_ptr[d]   = 0;
        end
    endtask

    // Advance one clock: predict combinational outputs and sample them mid-cycle,
    // then commit the model and sample the registered packet just after the edge.
    task automatic tick();
        logic [7:0] v;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            v = '0;
            for (int s = 0; s < n_of[d]; s++) v[s] = src_pkt(d, s).valid;
            ld[d]        = !m_valid[d] || rdy_of(d);
            win[d]       = ld[d] ? winner_of(v, n_of[d], mode_of[d] == 1 ? m_ptr[d] : 0) : -1;
            exp_ready[d] = (win[d] >= 0) ? (8'd1 << win[d]) : 8'd0;
            exp_conf[d]  = (win[d] >= 0) && ($countones(v) >= 2);
            cand[d]      = (win[d] >= 0) ? src_pkt(d, win[d]) : '0;
            obs_ready[d] = get_ready(d);
            obs_conf[d]  = get_conf(d);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (ld[d]) begin
                if (win[d] >= 0) begin
                    m_valid[d] = 1'b1;
                    m_pkt[d]   = cand[d];
                    if (mode_of[d] == 1) m_ptr[d] = (win[d] + 1) % n_of[d];
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
            obs_pkt[d] = get_pkt(d);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < n_of[d]; s++) set_src(d, s, rand_pkt());
            set_rdy(d, 1'b1);
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_ready(d) !== 8'd0) begin
                errors++;
                $display("FAIL reset_ready dut=%0d got=%b want=0", d, get_ready(d));
            end
            checks++;
            if (get_conf(d) !== 1'b0) begin
                errors++;
                $display("FAIL reset_conflict dut=%0d got=%b want=0", d, get_conf(d));
            end
            checks++;
            if (get_pkt(d) !== l2req_packet_t'(0)) begin
                errors++;
                $display("FAIL reset_packet dut=%0d got=%h want=0", d, get_pkt(d));
            end
        end
        idle_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_rr_rotation();
        idle_all();
        for (int s = 0; s < 3; s++) set_src(0, s, rand_pkt());
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (obs_ready[0] !== (8'd1 << (c % 3))) begin
                errors++;
                $display("FAIL rr_rotation c=%0d ready=%b want=%b", c, obs_ready[0], 8'd1 << (c % 3));
            end
            checks++;
            if (obs_conf[0] !== 1'b1) begin
                errors++;
                $display("FAIL rr_conflict c=%0d got=%b want=1", c, obs_conf[0]);
            end
            checks++;
            if (obs_pkt[0] !== m_pkt[0]) begin
                errors++;
                $display("FAIL rr_packet c=%0d got=%h want=%h", c, obs_pkt[0], m_pkt[0]);
            end
            set_src(0, c % 3, rand_pkt());
        end
    endtask

    task automatic test_fixed_priority();
        idle_all();
        set_src(1, 1, rand_pkt());
        set_src(1, 2, rand_pkt());
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (obs_ready[1] !== 8'b010) begin
                errors++;
                $display("FAIL fixed_priority c=%0d ready=%b want=010", c, obs_ready[1]);
            end
            checks++;
            if (obs_conf[1] !== 1'b1 || obs_pkt[1] !== m_pkt[1]) begin
                errors++;
                $display("FAIL fixed_out c=%0d conf=%b pkt=%h want conf=1 pkt=%h",
                         c, obs_conf[1], obs_pkt[1], m_pkt[1]);
            end
            set_src(1, 1, rand_pkt());
        end
    endtask

    task automatic test_single();
        l2req_packet_t p;
        idle_all();
        for (int c = 0; c < 5; c++) begin
            p = rand_pkt();
            set_src(2, 0, p);
            tick();
            checks++;
            if (obs_ready[2] !== 8'd1 || obs_conf[2] !== 1'b0) begin
                errors++;
                $display("FAIL single_ready c=%0d ready=%b conf=%b want ready=1 conf=0",
                         c, obs_ready[2], obs_conf[2]);
            end
            checks++;
            if (obs_pkt[2] !== p) begin
                errors++;
                $display("FAIL single_latency c=%0d got=%h want=%h", c, obs_pkt[2], p);
            end
        end
    endtask

    task automatic test_backpressure();
        l2req_packet_t held;
        int g;
        idle_all();
        for (int s = 0; s < 3; s++) set_src(0, s, rand_pkt());
        tick();
        g    = win[0];
        held = obs_pkt[0];
        if (g >= 0) set_src(0, g, rand_pkt());
        set_rdy(0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (obs_ready[0] !== 8'd0) begin
                errors++;
                $display("FAIL bp_ready c=%0d got=%b want=0", c, obs_ready[0]);
            end
            checks++;
            if (obs_pkt[0] !== held || held.valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c=%0d got=%h want=%h", c, obs_pkt[0], held);
            end
        end
        set_rdy(0, 1'b1);
        tick();
        checks++;
        if (obs_ready[0] !== (8'd1 << ((g + 1) % 3))) begin
            errors++;
            $display("FAIL bp_release ready=%b want=%b", obs_ready[0], 8'd1 << ((g + 1) % 3));
        end
        checks++;
        if (obs_pkt[0] !== m_pkt[0]) begin
            errors++;
            $display("FAIL bp_next_pkt got=%h want=%h", obs_pkt[0], m_pkt[0]);
        end
    endtask

    task automatic test_wrap();
        idle_all();
        set_src(0, 1, rand_pkt());
        tick();
        checks++;
        if (obs_ready[0] !== 8'b010) begin
            errors++;
            $display("FAIL wrap_setup ready=%b want=010", obs_ready[0]);
        end
        set_src(0, 1, '0);
        set_src(0, 0, rand_pkt());
        tick();
        checks++;
        if (obs_ready[0] !== 8'b001) begin
            errors++;
            $display("FAIL wrap_grant0 ready=%b want=001", obs_ready[0]);
        end
        for (int s = 0; s < 3; s++) set_src(0, s, rand_pkt());
        tick();
        checks++;
        if (obs_ready[0] !== 8'b010) begin
            errors++;
            $display("FAIL wrap_pointer ready=%b want=010", obs_ready[0]);
        end
    endtask

    task automatic test_random();
        l2req_packet_t cur;
        idle_all();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 3; d++) set_rdy(d, $urandom_range(0, 3) != 0);
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs_ready[d] !== exp_ready[d] || obs_conf[d] !== exp_conf[d]) begin
                    errors++;
                    $display("FAIL random_comb c=%0d dut=%0d ready=%b conf=%b want ready=%b conf=%b",
                             c, d, obs_ready[d], obs_conf[d], exp_ready[d], exp_conf[d]);
                end
                checks++;
                if (m_valid[d] ? (obs_pkt[d] !== m_pkt[d]) : (obs_pkt[d].valid !== 1'b0)) begin
                    errors++;
                    $display("FAIL random_pkt c=%0d dut=%0d got=%h want valid=%b pkt=%h",
                             c, d, obs_pkt[d], m_valid[d], m_pkt[d]);
                end
                for (int s = 0; s < n_of[d]; s++) begin
                    cur = src_pkt(d, s);
                    if (win[d] == s) begin
                        if ($urandom_range(0, 3) != 0) set_src(d, s, rand_pkt());
                        else set_src(d, s, '0);
                    end else if (!cur.valid && $urandom_range(0, 1) == 1) begin
                        set_src(d, s, rand_pkt());
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midissue();
        idle_all();
        for (int s = 0; s < 3; s++) set_src(0, s, rand_pkt());
        tick();
        set_rdy(0, 1'b0);
        tick();
        checks++;
        if (obs_pkt[0].valid !== 1'b1) begin
            errors++;
            $display("FAIL midissue_setup valid=%b want=1", obs_pkt[0].valid);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (if_rr.l2req_packet !== l2req_packet_t'(0)) begin
            errors++;
            $display("FAIL midissue_async_clear got=%h want=0", if_rr.l2req_packet);
        end
        checks++;
        if (if_rr.req_ready !== 3'b000 || conf_rr !== 1'b0) begin
            errors++;
            $display("FAIL midissue_quiet ready=%b conf=%b want 0", if_rr.req_ready, conf_rr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_rdy(0, 1'b1);
        tick();
        checks++;
        if (obs_ready[0] !== 8'b001) begin
            errors++;
            $display("FAIL midissue_ptr0 ready=%b want=001", obs_ready[0]);
        end
    endtask

    initial begin
        model_reset();
        idle_all();
        test_reset();
        test_rr_rotation();
        test_fixed_priority();
        test_single();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_midissue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
